// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse tracker: frame FSM states,
// byte0 field positions, default screen geometry and the axis clamp helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Bit positions inside the first byte of a movement packet
    localparam int SYNC_BIT = 3;
    localparam int XS       = 4;
    localparam int YS       = 5;
    localparam int XO       = 6;
    localparam int YO       = 7;

    // Default geometry and watchdog limit
    localparam int DEF_SCREEN_W       = 640;
    localparam int DEF_SCREEN_H       = 480;
    localparam int DEF_INIT_X         = 320;
    localparam int DEF_INIT_Y         = 240;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    // Clamp a signed 12-bit coordinate to [0, hi]
    function automatic logic [9:0] clamp_axis(input logic signed [11:0] v,
                                              input logic signed [11:0] hi);
        logic [9:0] r;
        if (v < 12'sd0) begin
            r = 10'd0;
        end else if (v > hi) begin
            r = hi[9:0];
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: synchronizes the raw bus, turns falling edges of the
// PS/2 clock into sample strobes and runs the start/data/parity/stop FSM.
// byte_valid / byte_err are single-cycle pulses one cycle after the stop strobe.
module ps2_rx_frame
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       abort,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       strobe,
    output logic       busy
);

    logic [1:0] raw_in;
    logic [1:0] sync_bits;

    assign raw_in = {ps2_data, ps2_clk};

    // Two-flop synchronizer per bus line, idling high like the bus itself
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic ps2_clk_sync;
    logic ps2_data_sync;
    logic clk_prev_reg;

    assign ps2_clk_sync  = sync_bits[0];
    assign ps2_data_sync = sync_bits[1];

    // Previous synced PS/2 clock for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= ps2_clk_sync;
        end
    end

    assign strobe = clk_prev_reg & ~ps2_clk_sync;

    frame_state_t state_reg, state_next;
    logic [2:0]   bit_idx_reg, bit_idx_next;
    logic [7:0]   shift_reg, shift_next;
    logic         parity_ok_reg, parity_ok_next;
    logic         byte_valid_reg, byte_valid_next;
    logic         byte_err_reg, byte_err_next;

    // Frame FSM state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'd0;
            parity_ok_reg  <= 1'b0;
            byte_valid_reg <= 1'b0;
            byte_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            parity_ok_reg  <= parity_ok_next;
            byte_valid_reg <= byte_valid_next;
            byte_err_reg   <= byte_err_next;
        end
    end

    // Next-state logic: one bit consumed per strobe, odd parity over data+parity
    always_comb begin
        state_next      = state_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        parity_ok_next  = parity_ok_reg;
        byte_valid_next = 1'b0;
        byte_err_next   = 1'b0;
        if (strobe) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!ps2_data_sync) begin
                        state_next   = ST_DATA;
                        bit_idx_next = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {ps2_data_sync, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_ok_next = ^{shift_reg, ps2_data_sync};
                    state_next     = ST_STOP;
                end
                ST_STOP: begin
                    if (ps2_data_sync && parity_ok_reg) begin
                        byte_valid_next = 1'b1;
                    end else begin
                        byte_err_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
        // A watchdog abort drops whatever frame is in progress
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    assign byte_data  = shift_reg;
    assign byte_valid = byte_valid_reg;
    assign byte_err   = byte_err_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte movement packets from ps2_rx_frame and
// keeps a clamped absolute cursor position plus button state.
// Optional feature macro: PS2_WATCHDOG_EN adds a stalled-frame/packet watchdog.
module ps2_mouse_tracker
    import ps2_pkg::*;
#(
    parameter int SCREEN_W       = DEF_SCREEN_W,
    parameter int SCREEN_H       = DEF_SCREEN_H,
    parameter int INIT_X         = DEF_INIT_X,
    parameter int INIT_Y         = DEF_INIT_Y,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic       pkt_valid,
    output logic       frame_err
);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_err;
    logic       sample_strobe;
    logic       frame_busy;
    logic       wd_abort;

    ps2_rx_frame u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .abort      (wd_abort),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .strobe     (sample_strobe),
        .busy       (frame_busy)
    );

    logic [1:0] byte_idx_reg;
    logic [2:0] hdr_btn_reg;
    logic       hdr_xs_reg, hdr_ys_reg, hdr_xo_reg, hdr_yo_reg;
    logic [7:0] byte1_reg, byte2_reg;
    logic       upd_reg;
    logic       sync_err;

    // A header byte without the sync bit is dropped and flagged
    assign sync_err = byte_valid && (byte_idx_reg == 2'd0) && !byte_data[SYNC_BIT];

    // Packet assembler: collect header, dx, dy; arm the position update after byte2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx_reg <= 2'd0;
            hdr_btn_reg  <= 3'd0;
            hdr_xs_reg   <= 1'b0;
            hdr_ys_reg   <= 1'b0;
            hdr_xo_reg   <= 1'b0;
            hdr_yo_reg   <= 1'b0;
            byte1_reg    <= 8'd0;
            byte2_reg    <= 8'd0;
            upd_reg      <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            if (wd_abort || byte_err) begin
                byte_idx_reg <= 2'd0;
            end else if (byte_valid) begin
                case (byte_idx_reg)
                    2'd0: begin
                        if (byte_data[SYNC_BIT]) begin
                            hdr_btn_reg  <= byte_data[2:0];
                            hdr_xs_reg   <= byte_data[XS];
                            hdr_ys_reg   <= byte_data[YS];
                            hdr_xo_reg   <= byte_data[XO];
                            hdr_yo_reg   <= byte_data[YO];
                            byte_idx_reg <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte1_reg    <= byte_data;
                        byte_idx_reg <= 2'd2;
                    end
                    default: begin
                        byte2_reg    <= byte_data;
                        byte_idx_reg <= 2'd0;
                        upd_reg      <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic signed [11:0] dx, dy, sum_x, sum_y;
    logic [9:0]         x_next, y_next;
    logic [9:0]         x_reg, y_reg;
    logic [2:0]         btn_reg;
    logic               pkt_valid_reg;

    // Deltas are 9-bit two's complement widened to 12 bits; overflow zeroes an axis.
    // y is subtracted because a positive PS/2 dy means upward motion.
    always_comb begin
        dx     = hdr_xo_reg ? 12'sd0 : $signed({{4{hdr_xs_reg}}, byte1_reg});
        dy     = hdr_yo_reg ? 12'sd0 : $signed({{4{hdr_ys_reg}}, byte2_reg});
        sum_x  = $signed({2'b00, x_reg}) + dx;
        sum_y  = $signed({2'b00, y_reg}) - dy;
        x_next = clamp_axis(sum_x, 12'(SCREEN_W - 1));
        y_next = clamp_axis(sum_y, 12'(SCREEN_H - 1));
    end

    // Output stage: position, buttons and the packet pulse change together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg         <= 10'(INIT_X);
            y_reg         <= 10'(INIT_Y);
            btn_reg       <= 3'd0;
            pkt_valid_reg <= 1'b0;
        end else begin
            pkt_valid_reg <= 1'b0;
            if (upd_reg) begin
                x_reg         <= x_next;
                y_reg         <= y_next;
                btn_reg       <= hdr_btn_reg;
                pkt_valid_reg <= 1'b1;
            end
        end
    end

`ifdef PS2_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            wd_fire_reg;
    logic            wd_active;

    assign wd_active = frame_busy || (byte_idx_reg != 2'd0);

    // Watchdog: counts idle time inside a frame or packet, fires once at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg  <= '0;
            wd_fire_reg <= 1'b0;
        end else begin
            wd_fire_reg <= 1'b0;
            if (sample_strobe || !wd_active || wd_fire_reg) begin
                wd_cnt_reg <= '0;
            end else if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_cnt_reg  <= '0;
                wd_fire_reg <= 1'b1;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
        end
    end

    assign wd_abort  = wd_fire_reg;
    assign frame_err = byte_err | sync_err | wd_fire_reg;
`else
    logic unused_wd;
    assign unused_wd = &{1'b0, frame_busy, sample_strobe, (TIMEOUT_CYCLES > 0)};
    assign wd_abort  = 1'b0;
    assign frame_err = byte_err | sync_err;
`endif

    assign mouse_x    = x_reg;
    assign mouse_y    = y_reg;
    assign btn_left   = btn_reg[0];
    assign btn_right  = btn_reg[1];
    assign btn_middle = btn_reg[2];
    assign pkt_valid  = pkt_valid_reg;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Testbench for ps2_mouse_tracker: directed packets plus random packets
// checked against a plain-arithmetic cursor model. Watchdog steps run only
// when PS2_WATCHDOG_EN is defined.
module tb_ps2_mouse_tracker;

    localparam int HALF = 8;      // clk cycles per PS/2 clock half period
    localparam int TO   = 3000;   // watchdog limit used in this bench

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] mouse_x, mouse_y;
    logic       btn_left, btn_right, btn_middle, pkt_valid, frame_err;

    always #5 clk = ~clk;

    ps2_mouse_tracker #(
        .SCREEN_W       (640),
        .SCREEN_H       (480),
        .INIT_X         (320),
        .INIT_Y         (240),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_middle (btn_middle),
        .pkt_valid  (pkt_valid),
        .frame_err  (frame_err)
    );

    int total = 0;
    int bad   = 0;
    int pkt_cnt = 0;
    int err_cnt = 0;
    int exp_x, exp_y;
    logic [2:0] exp_btn;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (pkt_valid === 1'b1) pkt_cnt <= pkt_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        wait_clk(20);
    endtask

    // Reference model: signed 9-bit deltas, overflow zeroes the axis, clamp to screen
    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (b0[6]) dx = 0;
        if (b0[7]) dy = 0;
        exp_x = exp_x + dx;
        exp_y = exp_y - dy;
        if (exp_x < 0) exp_x = 0;
        if (exp_x > 639) exp_x = 639;
        if (exp_y < 0) exp_y = 0;
        if (exp_y > 479) exp_y = 479;
        exp_btn = b0[2:0];
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".x"}, 32'(mouse_x), 32'(exp_x));
        chk({tag, ".y"}, 32'(mouse_y), 32'(exp_y));
        chk({tag, ".btn"}, 32'({btn_middle, btn_right, btn_left}), 32'(exp_btn));
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input string tag);
        int p0, e0;
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        model_packet(b0, b1, b2);
        check_state(tag);
        chk({tag, ".pkt"}, 32'(pkt_cnt - p0), 32'd1);
        chk({tag, ".err"}, 32'(err_cnt - e0), 32'd0);
        $display("packet %s: %02h %02h %02h -> x=%0d y=%0d btn=%b", tag, b0, b1, b2,
                 mouse_x, mouse_y, {btn_middle, btn_right, btn_left});
    endtask

    task automatic do_reset(input string tag);
        int p0, e0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b0;
        wait_clk(5);
        p0 = pkt_cnt;
        e0 = err_cnt;
        exp_x   = 320;
        exp_y   = 240;
        exp_btn = 3'b000;
        check_state({tag, ".in_reset"});
        reset = 1'b1;
        wait_clk(10);
        check_state({tag, ".released"});
        chk({tag, ".pkt"}, 32'(pkt_cnt - p0), 32'd0);
        chk({tag, ".err"}, 32'(err_cnt - e0), 32'd0);
        $display("reset %s: x=%0d y=%0d", tag, mouse_x, mouse_y);
    endtask

    initial begin
        int p0, e0;
        logic [7:0] r0, r1, r2;

        // Reset values
        do_reset("rst0");

        // Basic movement with left button
        send_packet(8'h09, 8'h05, 8'h03, "basic");

        // Negative dx, then X overflow with dy
        do_reset("rst1");
        send_packet(8'h18, 8'hF6, 8'h00, "neg_dx");
        send_packet(8'h49, 8'h10, 8'h02, "x_ovf");

        // Clamp at the right and bottom edges
        do_reset("rst2");
        send_packet(8'h08, 8'hFF, 8'h00, "right1");
        send_packet(8'h08, 8'hFF, 8'h00, "right_clamp");
        send_packet(8'h08, 8'h01, 8'h00, "right_hold");
        send_packet(8'h28, 8'h00, 8'h00, "bottom_clamp");

        // Clamp at the left and top edges
        do_reset("rst3");
        send_packet(8'h18, 8'h00, 8'h00, "left1");
        send_packet(8'h18, 8'h00, 8'h00, "left_clamp");
        send_packet(8'h18, 8'hFF, 8'h7F, "left_hold");
        send_packet(8'h08, 8'h00, 8'hFF, "top_clamp");

        // Bad parity on byte1: one error pulse, no packet; then recovery
        do_reset("rst4");
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'h08, 1'b0);
        send_byte(8'h04, 1'b1);
        chk("bad_parity.err", 32'(err_cnt - e0), 32'd1);
        chk("bad_parity.pkt", 32'(pkt_cnt - p0), 32'd0);
        check_state("bad_parity.state");
        send_packet(8'h0A, 8'h01, 8'h01, "after_parity");

        // Header without sync bit is dropped and flagged; idle-level strobes are ignored
        e0 = err_cnt;
        send_byte(8'h00, 1'b0);
        chk("no_sync.err", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt;
        send_bit(1'b1);
        send_bit(1'b1);
        wait_clk(20);
        chk("idle_strobe.err", 32'(err_cnt - e0), 32'd0);
        send_packet(8'h0C, 8'h00, 8'h00, "after_sync");

        // Reset asserted mid-frame and mid-packet
        send_byte(8'h09, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset("mid_frame");
        send_packet(8'h09, 8'h02, 8'h02, "after_mid");

        // Random packets against the model
        for (int i = 0; i < 20; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r0[3] = 1'b1;
            send_packet(r0, r1, r2, $sformatf("rnd%0d", i));
        end

`ifdef PS2_WATCHDOG_EN
        // Stalled packet times out once, then a fresh packet is accepted
        do_reset("rst_wd");
        e0 = err_cnt;
        p0 = pkt_cnt;
        send_byte(8'h08, 1'b0);
        wait_clk(TO + 100);
        chk("watchdog.err", 32'(err_cnt - e0), 32'd1);
        chk("watchdog.pkt", 32'(pkt_cnt - p0), 32'd0);
        send_packet(8'h08, 8'h02, 8'h00, "after_wd");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

Receives the PS/2 mouse serial stream, assembles standard 3-byte movement packets and keeps an absolute cursor position clamped to the visible screen. It is the producer side of the `mouse_x`/`mouse_y` interface used by the graphics/rope renderer, and it also publishes the button state. It is receive-only: the mouse is already in stream mode when this block sees it.

## Interface
Parameters:
- `SCREEN_W`, 640, horizontal pixel count; x range is 0..SCREEN_W-1.
- `SCREEN_H`, 480, vertical pixel count; y range is 0..SCREEN_H-1.
- `INIT_X`, 320, x position after reset.
- `INIT_Y`, 240, y position after reset.
- `TIMEOUT_CYCLES`, 100000, watchdog limit in clk cycles; used only with `PS2_WATCHDOG_EN`.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock; asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data; asynchronous to `clk`.
- `mouse_x`  out  10  cursor x, unsigned pixels.
- `mouse_y`  out  10  cursor y, unsigned pixels; 0 is the top row.
- `btn_left`, `btn_right`, `btn_middle`  out  1 each  button state from the last accepted packet.
- `pkt_valid`  out  1  one-cycle pulse when a packet updates the outputs.
- `frame_err`  out  1  one-cycle pulse on a discarded frame or on a watchdog timeout.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - A falling edge of the synced `ps2_clk` is a sample strobe.
- Frame FSM (in `ps2_rx_frame`), states IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: advance on a strobe with data=0 (start bit). A strobe with data=1 stays in IDLE and does not raise `frame_err`.
  - DATA: 8 strobes, LSB first, into a shift register with a 3-bit index.
  - PARITY: sample the parity bit. The frame is correct when the 8 data bits plus the parity bit have odd parity.
  - STOP: the bit must be 1. If parity or stop is bad, pulse `frame_err`, drop the byte and return to IDLE.
- Packet assembler, byte index 0..2:
  - Byte0 must have bit3 = 1. If it does not, the byte is dropped, `frame_err` pulses and the index stays 0.
  - Byte0 fields: bit0 = L, bit1 = R, bit2 = M, bit4 = X sign, bit5 = Y sign, bit6 = X overflow, bit7 = Y overflow.
  - dx = 9-bit two's complement {Xsign, byte1}. dy = {Ysign, byte2}.
  - Any frame error resets the index to 0.
- Position update, once byte2 is accepted:
  - Arithmetic is 12-bit signed: x' = x + dx and y' = y - dy, because PS/2 +dy means up.
  - If an axis overflow bit is set, that axis delta is forced to 0.
  - Each result is clamped to [0, SCREEN_W-1] and [0, SCREEN_H-1].
  - Buttons are latched from byte0 of the same packet.
  - All outputs update together and `pkt_valid` pulses.

## Timing
- Reset values:
  - `mouse_x` = INIT_X, `mouse_y` = INIT_Y.
  - Buttons, `pkt_valid` and `frame_err` = 0.
  - FSM in IDLE, byte index 0, synchronizers at 1 (idle bus level).
- Latency:
  - Cycle E is the cycle in which the stop-bit strobe is detected.
  - The internal byte-valid signal is high in E+1.
  - For byte2, position, buttons and `pkt_valid` update on the edge ending E+2.
  - `frame_err` is asserted in E+1.
- Strobes are at least 2000 clk cycles apart in normal operation, so a byte and a strobe never collide in the assembler.
- Reset asserted mid-frame: the frame and any partial packet are abandoned. No pulse is emitted on reset release.
- Clamp cases: x stays 0 under a negative dx, and x stays SCREEN_W-1 under a positive dx. The same holds for y.

## Configuration
- `PS2_WATCHDOG_EN` defined:
  - A counter runs while the frame FSM is not IDLE or the byte index is not 0, and clears on every strobe.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, the index goes to 0 and `frame_err` pulses once.
- `PS2_WATCHDOG_EN` undefined:
  - There is no counter, and a partial frame or packet waits indefinitely.
  - Resynchronization relies only on the bit3 check.

## Structure
- `ps2_pkg` holds:
  - the frame-state enum;
  - byte0 bit-position constants (SYNC_BIT=3, XS=4, YS=5, XO=6, YO=7);
  - default screen constants.
- Sub-module `ps2_rx_frame` contains the synchronizers, edge detect, frame FSM and parity check. It outputs `byte_data[7:0]`, `byte_valid` and `byte_err`.
- Top-level `ps2_mouse_tracker` contains the packet assembler, the clamp arithmetic and the watchdog.

## Test plan
- Reset held low, then released -> `mouse_x`=320, `mouse_y`=240, all buttons 0, no pulses.
- Packet 0x09, 0x05, 0x03 sent from reset -> x=325, y=237, `btn_left`=1, exactly one `pkt_valid` pulse at E+2 of byte2.
- Packet 0x18, 0xF6, 0x00 sent from reset -> x=310 (dx=-10), y=240. Packet 0x49, 0x10, 0x02 -> x unchanged (X overflow), y decreases by 2.
- Packets 0x08, 0xFF, 0x00 twice from reset -> x=575, then 639 (clamped). Packet 0x28, 0x00, 0x00 -> dy=-256, y=479 (clamped).
- Byte1 sent with a wrong parity bit -> `frame_err` pulse, no `pkt_valid`. A following valid packet 0x0A, 0x01, 0x01 is accepted and `btn_right`=1.
- With `PS2_WATCHDOG_EN` defined: send byte0 0x08 only, then idle 100001 cycles -> one `frame_err` pulse. Packet 0x08, 0x02, 0x00 then gives x=322.
